// File: rtl/multicycle_control_fsm.sv
// Main control unit for the multicycle MIPS datapath.
// Steps one state per clock through fetch/decode/execute/memory/writeback,
// waits on the memory ready handshake in FETCH, MEMRD and MEMWR, and decodes
// every datapath enable and mux select from the current state.
module multicycle_control_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [5:0] op_q_reg;

    assign state = state_reg;

    // State register; the opcode is captured in DECODE so later IR changes
    // cannot redirect an instruction already in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            op_q_reg  <= 6'h00;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE) begin
                op_q_reg <= opcode;
            end
        end
    end

    // Next-state selection; unused encodings recover to FETCH.
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_next = S_MEMADR;
                end else if (opcode == OP_RTYPE) begin
                    state_next = S_EXEC;
                end else if (opcode == OP_BEQ) begin
                    state_next = S_BRANCH;
                end else if (opcode == OP_ADDI) begin
                    state_next = S_ADDIEX;
                end else if (opcode == OP_J) begin
                    state_next = S_JUMP;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEMADR: state_next = (op_q_reg == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_next = S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_ADDIEX: state_next = S_ADDIWB;
            S_ADDIWB: state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    // Output decode from the current state; the handshake-dependent outputs
    // follow mem_ready within the same cycle so the access completes on time.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (!(opcode == OP_LW || opcode == OP_SW || opcode == OP_RTYPE ||
                      opcode == OP_BEQ || opcode == OP_ADDI || opcode == OP_J)) begin
                    illegal_op = 1'b1;
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_source     = 2'b01;
                pc_write_cond = 1'b1;
                instr_done    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_source  = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed testbench for multicycle_control_fsm. Each stimulus cycle pushes
// the hand-computed expected state and output vector into a queue; a monitor
// on the falling edge pops and compares against what the DUT presents.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    // Output vector: pcw pcwc iord mrd mwr irw | rdst m2r rw asa | asb | aop | psrc | done ill
    logic [17:0] outs;
    assign outs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                   reg_dst, mem_to_reg, reg_write, alu_src_a,
                   alu_src_b, alu_op, pc_source, instr_done, illegal_op};

    localparam logic [17:0] O_IDLE    = 18'b000000_0000_00_00_00_00;
    localparam logic [17:0] O_F_RDY   = 18'b100101_0000_01_00_00_00;
    localparam logic [17:0] O_F_WAIT  = 18'b000100_0000_01_00_00_00;
    localparam logic [17:0] O_DEC     = 18'b000000_0000_11_00_00_00;
    localparam logic [17:0] O_DEC_ILL = 18'b000000_0000_11_00_00_01;
    localparam logic [17:0] O_MEMADR  = 18'b000000_0001_10_00_00_00;
    localparam logic [17:0] O_MEMRD   = 18'b001100_0000_00_00_00_00;
    localparam logic [17:0] O_MEMWB   = 18'b000000_0110_00_00_00_10;
    localparam logic [17:0] O_MWR_W   = 18'b001010_0000_00_00_00_00;
    localparam logic [17:0] O_MWR_D   = 18'b001010_0000_00_00_00_10;
    localparam logic [17:0] O_EXEC    = 18'b000000_0001_00_10_00_00;
    localparam logic [17:0] O_ALUWB   = 18'b000000_1010_00_00_00_10;
    localparam logic [17:0] O_BRANCH  = 18'b010000_0001_00_01_01_10;
    localparam logic [17:0] O_ADDIEX  = 18'b000000_0001_10_00_00_00;
    localparam logic [17:0] O_ADDIWB  = 18'b000000_0010_00_00_00_10;
    localparam logic [17:0] O_JUMP    = 18'b100000_0000_00_00_10_10;

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic [17:0] o;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check({mon_e.name, ".state"}, {28'd0, state}, {28'd0, mon_e.st});
            check({mon_e.name, ".outs"}, {14'd0, outs}, {14'd0, mon_e.o});
            $display("cycle %-12s state=%0d outs=%b", mon_e.name, state, outs);
        end
        if (instr_done === 1'b1) done_cnt++;
    end

    // Drive one cycle of inputs and queue what the DUT must show during it.
    task automatic step(input string name, input logic rst, input logic [5:0] op,
                        input logic rdy, input logic [3:0] st, input logic [17:0] o);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        opcode    = op;
        mem_ready = rdy;
        e.name = name;
        e.st   = st;
        e.o    = o;
        sb_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int d1;
        reset     = 1'b1;
        opcode    = 6'h00;
        mem_ready = 1'b0;

        step("rst0", 1'b1, 6'h00, 1'b0, 4'd0, O_IDLE);
        step("rst1", 1'b1, 6'h00, 1'b0, 4'd0, O_IDLE);
        step("release", 1'b0, 6'h00, 1'b1, 4'd0, O_IDLE);

        // R-type
        step("r_fetch", 1'b0, 6'h00, 1'b1, 4'd1, O_F_RDY);
        step("r_decode", 1'b0, 6'h00, 1'b1, 4'd2, O_DEC);
        step("r_exec", 1'b0, 6'h00, 1'b1, 4'd7, O_EXEC);
        step("r_aluwb", 1'b0, 6'h00, 1'b1, 4'd8, O_ALUWB);

        // LW with three wait cycles in MEMRD
        step("lw_fetch", 1'b0, 6'h23, 1'b1, 4'd1, O_F_RDY);
        d0 = done_cnt;
        step("lw_decode", 1'b0, 6'h23, 1'b1, 4'd2, O_DEC);
        step("lw_memadr", 1'b0, 6'h23, 1'b1, 4'd3, O_MEMADR);
        step("lw_memrd_w0", 1'b0, 6'h23, 1'b0, 4'd4, O_MEMRD);
        step("lw_memrd_w1", 1'b0, 6'h23, 1'b0, 4'd4, O_MEMRD);
        step("lw_memrd_w2", 1'b0, 6'h23, 1'b0, 4'd4, O_MEMRD);
        step("lw_memrd_ok", 1'b0, 6'h23, 1'b1, 4'd4, O_MEMRD);
        step("lw_memwb", 1'b0, 6'h23, 1'b1, 4'd5, O_MEMWB);

        // BEQ then J
        step("beq_fetch", 1'b0, 6'h04, 1'b1, 4'd1, O_F_RDY);
        d1 = done_cnt;
        check("lw_done_once", d1 - d0, 1);
        step("beq_decode", 1'b0, 6'h04, 1'b1, 4'd2, O_DEC);
        step("beq_branch", 1'b0, 6'h04, 1'b1, 4'd9, O_BRANCH);
        step("j_fetch", 1'b0, 6'h02, 1'b1, 4'd1, O_F_RDY);
        step("j_decode", 1'b0, 6'h02, 1'b1, 4'd2, O_DEC);
        step("j_jump", 1'b0, 6'h02, 1'b1, 4'd12, O_JUMP);

        // Illegal opcode, with one fetch wait cycle first
        step("ill_fetch_w", 1'b0, 6'h3F, 1'b0, 4'd1, O_F_WAIT);
        step("ill_fetch", 1'b0, 6'h3F, 1'b1, 4'd1, O_F_RDY);
        step("ill_decode", 1'b0, 6'h3F, 1'b1, 4'd2, O_DEC_ILL);

        // SW with opcode flipped to LW during MEMADR; one MEMWR wait
        step("sw_fetch", 1'b0, 6'h2B, 1'b1, 4'd1, O_F_RDY);
        step("sw_decode", 1'b0, 6'h2B, 1'b1, 4'd2, O_DEC);
        step("sw_memadr", 1'b0, 6'h23, 1'b1, 4'd3, O_MEMADR);
        step("sw_memwr_w", 1'b0, 6'h23, 1'b0, 4'd6, O_MWR_W);
        step("sw_memwr", 1'b0, 6'h23, 1'b1, 4'd6, O_MWR_D);

        // ADDI
        step("addi_fetch", 1'b0, 6'h08, 1'b1, 4'd1, O_F_RDY);
        step("addi_decode", 1'b0, 6'h08, 1'b1, 4'd2, O_DEC);
        step("addi_ex", 1'b0, 6'h08, 1'b1, 4'd10, O_ADDIEX);
        step("addi_wb", 1'b0, 6'h08, 1'b1, 4'd11, O_ADDIWB);

        // Reset asserted while stalled in MEMRD
        step("rs_fetch", 1'b0, 6'h23, 1'b1, 4'd1, O_F_RDY);
        step("rs_decode", 1'b0, 6'h23, 1'b1, 4'd2, O_DEC);
        step("rs_memadr", 1'b0, 6'h23, 1'b1, 4'd3, O_MEMADR);
        step("rs_memrd", 1'b0, 6'h23, 1'b0, 4'd4, O_MEMRD);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst.state", {28'd0, state}, 32'd0);
        check("async_rst.outs", {14'd0, outs}, {14'd0, O_IDLE});
        $display("async reset mid-MEMRD state=%0d outs=%b", state, outs);
        step("rs_hold", 1'b1, 6'h23, 1'b1, 4'd0, O_IDLE);
        step("rs_release", 1'b0, 6'h00, 1'b1, 4'd0, O_IDLE);
        step("rs_refetch", 1'b0, 6'h00, 1'b1, 4'd1, O_F_RDY);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
